nx_stream_arbiter: RTL and testbench

- Merges four inbound message streams (north, east, south, west) into one outbound stream.
- Tags each outbound message with the 2-bit direction it arrived from.
- Uses fair round-robin arbitration and a single registered output slot.
- Sits upstream of a node's ingress logic. It is the converging counterpart to the per-node stream distributor and shares the same valid/ready handshake and direction encoding.

---
 rtl/nx_constants.sv | 24 ++
 rtl/nx_rr_select.sv | 38 +++
 rtl/nx_stream_arbiter.sv | 102 ++++++++++
 tb/tb_nx_stream_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nx_constants.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nx_constants                                                    |
// | Brief    : Direction encoding shared by the stream arbiter and distributor |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package nx_constants;

   typedef logic [1:0] direction_t;

   localparam direction_t DIRX_NORTH = 2'd0;
   localparam direction_t DIRX_EAST  = 2'd1;
   localparam direction_t DIRX_SOUTH = 2'd2;
   localparam direction_t DIRX_WEST  = 2'd3;

   localparam int unsigned NUM_DIRS = 4;

   // Next direction in the cyclic N,E,S,W order; wraps naturally in 2 bits.
   function automatic direction_t dir_next(input direction_t d);
      return d + direction_t'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nx_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nx_rr_select                                                    |
// | Brief    : Combinational 4-way round-robin picker (search from last + 1)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nx_rr_select
   import nx_constants::*;
(
   input  logic [3:0] i_req,
   input  direction_t i_last,
   output logic [3:0] o_grant,
   output direction_t o_winner,
   output logic       o_any
);

   direction_t w_idx;
   logic       w_found;

   // The last-served direction is visited last, giving it the lowest priority.
   always_comb begin
      o_winner = i_last;
      w_found  = 1'b0;
      w_idx    = i_last;
      for (int k = 1; k <= 4; k++) begin
         w_idx = i_last + direction_t'(k);
         if (!w_found && i_req[w_idx]) begin
            w_found  = 1'b1;
            o_winner = w_idx;
         end
      end
   end

   assign o_any   = |i_req;
   assign o_grant = o_any ? (4'b0001 << o_winner) : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/nx_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nx_stream_arbiter                                               |
// | Brief    : Round-robin merge of N/E/S/W streams into one registered slot   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nx_stream_arbiter
   import nx_constants::*;
#(
   parameter int STREAM_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic [STREAM_WIDTH-1:0] north_data_i,
   input  logic                    north_valid_i,
   output logic                    north_ready_o,

   input  logic [STREAM_WIDTH-1:0] east_data_i,
   input  logic                    east_valid_i,
   output logic                    east_ready_o,

   input  logic [STREAM_WIDTH-1:0] south_data_i,
   input  logic                    south_valid_i,
   output logic                    south_ready_o,

   input  logic [STREAM_WIDTH-1:0] west_data_i,
   input  logic                    west_valid_i,
   output logic                    west_ready_o,

   output logic [STREAM_WIDTH-1:0] arb_data_o,
   output direction_t              arb_dir_o,
   output logic                    arb_valid_o,
   input  logic                    arb_ready_i
);

   logic [STREAM_WIDTH-1:0] r_data;
   direction_t              r_dir;
   logic                    r_valid;
   direction_t              r_last;

   logic [3:0]              w_req;
   logic [3:0]              w_grant;
   direction_t              w_winner;
   logic                    w_any;
   logic                    w_can_accept;
   logic                    w_accept;
   logic [STREAM_WIDTH-1:0] w_win_data;

   assign w_req = {west_valid_i, south_valid_i, east_valid_i, north_valid_i};

   nx_rr_select u_rr_select (
      .i_req    (w_req),
      .i_last   (r_last),
      .o_grant  (w_grant),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   // Draining the slot in the same cycle frees it, so a refill needs no bubble.
   assign w_can_accept = !r_valid || arb_ready_i;
   assign w_accept     = w_any && w_can_accept;

   assign north_ready_o = w_grant[DIRX_NORTH] && w_can_accept && !rst_i;
   assign east_ready_o  = w_grant[DIRX_EAST]  && w_can_accept && !rst_i;
   assign south_ready_o = w_grant[DIRX_SOUTH] && w_can_accept && !rst_i;
   assign west_ready_o  = w_grant[DIRX_WEST]  && w_can_accept && !rst_i;

   always_comb begin
      w_win_data = north_data_i;
      case (w_winner)
         DIRX_NORTH: w_win_data = north_data_i;
         DIRX_EAST:  w_win_data = east_data_i;
         DIRX_SOUTH: w_win_data = south_data_i;
         DIRX_WEST:  w_win_data = west_data_i;
         default:    w_win_data = north_data_i;
      endcase
   end

   // Pointer starts at west so north wins the first arbitration after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_dir   <= DIRX_NORTH;
         r_last  <= DIRX_WEST;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= w_win_data;
         r_dir   <= w_winner;
         r_last  <= w_winner;
      end else if (arb_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign arb_data_o  = r_data;
   assign arb_dir_o   = r_dir;
   assign arb_valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_nx_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nx_stream_arbiter                                            |
// | Brief    : Randomized scoreboard bench for nx_stream_arbiter               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_nx_stream_arbiter;

   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [W-1:0]  s_data [4];
   logic [3:0]    s_valid;
   logic [3:0]    rdy_vec;
   logic          north_ready_o, east_ready_o, south_ready_o, west_ready_o;
   logic [W-1:0]  arb_data_o;
   logic [1:0]    arb_dir_o;
   logic          arb_valid_o;
   logic          arb_ready_i;

   int            checks = 0;
   int            errors = 0;
   logic [W+1:0]  exp_q [$];

   // Reference state: is the output slot occupied, and who was served last.
   bit            m_valid;
   int            m_last;
   logic [3:0]    acc_prev;

   nx_stream_arbiter #(.STREAM_WIDTH(W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .north_data_i  (s_data[0]),
      .north_valid_i (s_valid[0]),
      .north_ready_o (north_ready_o),
      .east_data_i   (s_data[1]),
      .east_valid_i  (s_valid[1]),
      .east_ready_o  (east_ready_o),
      .south_data_i  (s_data[2]),
      .south_valid_i (s_valid[2]),
      .south_ready_o (south_ready_o),
      .west_data_i   (s_data[3]),
      .west_valid_i  (s_valid[3]),
      .west_ready_o  (west_ready_o),
      .arb_data_o    (arb_data_o),
      .arb_dir_o     (arb_dir_o),
      .arb_valid_o   (arb_valid_o),
      .arb_ready_i   (arb_ready_i)
   );

   assign rdy_vec = {west_ready_o, south_ready_o, east_ready_o, north_ready_o};

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: mid-cycle, the slot content must match the oldest expected message.
   always @(negedge clk_i) begin
      if (!rst_i && arb_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output actual=%h/%0d expected=none", arb_data_o, arb_dir_o);
         end else begin
            check("out_dir_data", {30'd0, arb_dir_o, arb_data_o}, {30'd0, exp_q[0]});
            if (arb_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic start_cycle();
      @(posedge clk_i);
      #2;
      for (int i = 0; i < 4; i++)
         if (acc_prev[i]) s_valid[i] = 1'b0;
      acc_prev = 4'b0000;
   endtask

   // Round-robin rule: scan from the last-served direction + 1, first requester wins.
   task automatic evaluate();
      bit         can_acc;
      int         win;
      logic [3:0] expv;
      #1;
      can_acc = !m_valid || arb_ready_i;
      win = -1;
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (m_last + k) % 4;
         if (win < 0 && s_valid[idx]) win = idx;
      end
      expv = 4'b0000;
      if (win >= 0 && can_acc) expv[win] = 1'b1;
      check("ready_vec", {60'd0, rdy_vec}, {60'd0, expv});
      if (expv != 4'b0000) begin
         exp_q.push_back({2'(win), s_data[win]});
         m_valid = 1'b1;
         m_last = win;
         acc_prev[win] = 1'b1;
      end else if (arb_ready_i) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic rand_cycle(input int pv, input int pr);
      start_cycle();
      for (int i = 0; i < 4; i++)
         if (!s_valid[i] && $urandom_range(99) < pv) begin
            s_valid[i] = 1'b1;
            s_data[i] = $urandom;
         end
      arb_ready_i = ($urandom_range(99) < pr);
      evaluate();
   endtask

   initial begin
      rst_i = 1'b1;
      arb_ready_i = 1'b0;
      s_valid = 4'b1111;
      for (int i = 0; i < 4; i++) s_data[i] = 32'h1000_0000 + i;
      m_valid = 1'b0;
      m_last = 3;
      acc_prev = 4'b0000;

      #12;
      check("reset_ready", {60'd0, rdy_vec}, 64'd0);
      check("reset_valid", {63'd0, arb_valid_o}, 64'd0);
      check("reset_dir", {62'd0, arb_dir_o}, 64'd0);
      check("reset_data", {32'd0, arb_data_o}, 64'd0);
      s_valid = 4'b0000;
      #5 rst_i = 1'b0;

      // Idle, then a lone east request with the slot draining.
      start_cycle();
      arb_ready_i = 1'b1;
      evaluate();
      start_cycle();
      s_valid[1] = 1'b1;
      s_data[1] = 32'hA5A5_0001;
      arb_ready_i = 1'b1;
      evaluate();

      // Continuous requests from all four at full throughput.
      for (int c = 0; c < 10; c++) rand_cycle(100, 100);
      // Heavy backpressure, then mixed random traffic.
      for (int c = 0; c < 60; c++) rand_cycle(90, 20);
      for (int c = 0; c < 300; c++) rand_cycle(40, 70);
      for (int c = 0; c < 100; c++) rand_cycle(15, 90);

      // Fill the slot, then reset asynchronously between edges.
      for (int c = 0; c < 50 && !m_valid; c++) rand_cycle(80, 30);
      @(posedge clk_i);
      #4;
      check("slot_full_before_rst", {63'd0, arb_valid_o}, {63'd0, m_valid});
      rst_i = 1'b1;
      #1;
      check("rst_async_valid", {63'd0, arb_valid_o}, 64'd0);
      check("rst_ready", {60'd0, rdy_vec}, 64'd0);
      for (int i = 0; i < 4; i++)
         if (acc_prev[i]) s_valid[i] = 1'b0;
      acc_prev = 4'b0000;
      exp_q.delete();
      m_valid = 1'b0;
      m_last = 3;
      #3 rst_i = 1'b0;

      start_cycle();
      for (int i = 0; i < 4; i++)
         if (!s_valid[i]) begin
            s_valid[i] = 1'b1;
            s_data[i] = $urandom;
         end
      arb_ready_i = 1'b0;
      evaluate();
      check("post_rst_north_first", {60'd0, rdy_vec}, 64'd1);

      for (int c = 0; c < 200; c++) rand_cycle(50, 60);
      for (int c = 0; c < 20; c++) rand_cycle(0, 100);
      @(negedge clk_i);
      @(negedge clk_i);
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
